imem_loader: RTL and testbench

Program loader that writes the instruction memory the CPU core fetches from. It accepts a byte stream over a valid/ready handshake, assembles bytes into instruction words, and issues one write per word to the instruction memory write port. It holds the CPU in reset (`cpu_reset`) until a complete program has been written. It sits between the host/bench byte source and the CPU's instruction memory.

---
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Program loader: packs a valid/ready byte stream MSB-first into instruction words,
// writes them to instruction memory, and holds the CPU in reset until a full program is in place.
module imem_loader #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W:0]    word_count,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int BYTES = INSTR_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t          state, state_nxt;
    logic [ADDR_W:0] count;
    logic [BCW-1:0]  byte_cnt;
    logic            can_start, count_ok, load_go, load_bad;
    logic            accept, last_byte, last_word;

    assign count_ok  = (word_count != '0) && (word_count <= DEPTH_W);
    assign can_start = (state == IDLE) || (state == DONE);
    assign load_go   = start && can_start && count_ok;
    assign load_bad  = start && can_start && !count_ok;
    assign accept    = byte_ready && byte_valid;
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign last_word = ({1'b0, imem_addr} == count - 1'b1);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (load_go)       state_nxt = RECV;
                else if (load_bad) state_nxt = IDLE;
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && last_byte) state_nxt = WRITE;
            end
            WRITE: begin
                imem_we   = 1'b1;
                busy      = 1'b1;
                state_nxt = last_word ? DONE : RECV;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            byte_cnt   <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (load_go) begin
                count     <= word_count;
                byte_cnt  <= '0;
                imem_addr <= '0;
                cpu_reset <= 1'b1;
                done      <= 1'b0;
                err       <= 1'b0;
            end else if (load_bad) begin
                err <= 1'b1;
            end

            // Shifting left leaves the first byte of a word in the top lane once it is complete.
            if (accept) begin
                imem_wdata <= (imem_wdata << 8) | INSTR_W'(byte_data);
                byte_cnt   <= last_byte ? '0 : byte_cnt + 1'b1;
            end

            if (state == WRITE) begin
                if (last_word) begin
                    done      <= 1'b1;
                    cpu_reset <= 1'b0;
                end else begin
                    imem_addr <= imem_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams compared against a
// word-packing model and a list of expected memory writes.
module tb_imem_loader;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 5;
    localparam int BYTES   = INSTR_W / 8;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int BUDGET  = 5000;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [ADDR_W:0]    word_count = '0;
    logic               byte_valid = 1'b0;
    logic [7:0]         byte_data = '0;
    logic               byte_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               cpu_reset, busy, done, err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
    } wr_t;

    wr_t wr_q[$];
    int  accepted = 0;

    imem_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Sole writer of the observation records; tests only read them.
    always @(negedge clk) begin
        if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
        if (byte_valid && byte_ready) accepted++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start      = 1'b1;
        word_count = n[ADDR_W:0];
        tick();
        start      = 1'b0;
    endtask

    // mode 0: valid always high, 1: valid toggles 1/0, 2: random valid
    task automatic feed(input logic [7:0] bytes[$], input int mode, output int cyc, output bit ok);
        int idx = 0;
        bit v, acc;
        cyc = 0;
        while (idx < bytes.size() && cyc < BUDGET) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            byte_valid = v;
            byte_data  = v ? bytes[idx] : 8'($urandom);
            acc        = v && byte_ready;
            tick();
            cyc++;
            if (acc) idx++;
        end
        byte_valid = 1'b0;
        while (!done && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        ok = done;
    endtask

    // Full load scenario: start, stream, then compare every write against the packing model.
    task automatic load_and_verify(input string name, input int n, input int mode,
                                   input logic [7:0] bytes[$], output int cyc);
        int wb = wr_q.size();
        int ab = accepted;
        bit ok;
        logic [INSTR_W-1:0] exp_d;
        do_start(n);
        checks++;
        if ({busy, byte_ready, cpu_reset, done, err} !== 5'b11100) begin
            errors++;
            $display("FAIL %s start: busy/ready/cpu_reset/done/err = %b, expected 11100", name,
                     {busy, byte_ready, cpu_reset, done, err});
        end
        feed(bytes, mode, cyc, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout: done not seen within %0d cycles", name, BUDGET);
        end
        checks++;
        if ({done, cpu_reset, busy} !== 3'b100) begin
            errors++;
            $display("FAIL %s end: done/cpu_reset/busy = %b, expected 100", name, {done, cpu_reset, busy});
        end
        checks++;
        if (wr_q.size() - wb != n) begin
            errors++;
            $display("FAIL %s write count: got %0d, expected %0d", name, wr_q.size() - wb, n);
        end
        checks++;
        if (accepted - ab != n * BYTES) begin
            errors++;
            $display("FAIL %s accepted bytes: got %0d, expected %0d", name, accepted - ab, n * BYTES);
        end
        for (int i = 0; i < n && wb + i < wr_q.size(); i++) begin
            exp_d = '0;
            for (int b = 0; b < BYTES; b++) exp_d = (exp_d << 8) | INSTR_W'(bytes[i * BYTES + b]);
            checks++;
            if (wr_q[wb + i].addr !== ADDR_W'(i) || wr_q[wb + i].data !== exp_d) begin
                errors++;
                $display("FAIL %s word %0d: got addr %0d data %h, expected addr %0d data %h", name, i,
                         wr_q[wb + i].addr, wr_q[wb + i].data, i, exp_d);
            end
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({cpu_reset, byte_ready, imem_we, busy, done, err} !== 6'b100000 ||
            imem_addr !== '0 || imem_wdata !== '0) begin
            errors++;
            $display("FAIL reset async: cpu_reset/ready/we/busy/done/err = %b addr %0d data %h, expected 100000 0 0",
                     {cpu_reset, byte_ready, imem_we, busy, done, err}, imem_addr, imem_wdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) tick();
        checks++;
        if ({cpu_reset, byte_ready, busy} !== 3'b100 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL reset idle: cpu_reset/ready/busy = %b writes %0d, expected 100 0",
                     {cpu_reset, byte_ready, busy}, wr_q.size());
        end
    endtask

    task automatic test_single_word();
        logic [7:0] bytes[$] = '{8'hA5, 8'h3C};
        int cyc;
        load_and_verify("single", 1, 0, bytes, cyc);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL single latency: got %0d cycles, expected 3", cyc);
        end
        checks++;
        if (wr_q.size() == 0 || wr_q[wr_q.size() - 1].data !== 16'hA53C) begin
            errors++;
            $display("FAIL single data: got %h, expected a53c",
                     wr_q.size() ? wr_q[wr_q.size() - 1].data : 16'h0);
        end
    endtask

    task automatic test_full_depth();
        logic [7:0] bytes[$];
        int cyc;
        for (int i = 0; i < DEPTH; i++) begin
            bytes.push_back(8'(i));
            bytes.push_back(~8'(i));
        end
        load_and_verify("full", DEPTH, 0, bytes, cyc);
        checks++;
        if (cyc != DEPTH * (BYTES + 1)) begin
            errors++;
            $display("FAIL full latency: got %0d cycles, expected %0d", cyc, DEPTH * (BYTES + 1));
        end
        checks++;
        if (imem_addr !== ADDR_W'(DEPTH - 1)) begin
            errors++;
            $display("FAIL full final addr: got %0d, expected %0d", imem_addr, DEPTH - 1);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] bytes[$];
        int cyc;
        for (int i = 0; i < 2 * BYTES; i++) bytes.push_back(8'($urandom));
        load_and_verify("backpressure", 2, 1, bytes, cyc);
    endtask

    task automatic test_illegal_count();
        int wb = wr_q.size();
        logic [7:0] bytes[$] = '{8'h12, 8'h34};
        int cyc;
        do_start(0);
        checks++;
        if ({err, busy, byte_ready, cpu_reset} !== 4'b1000) begin
            errors++;
            $display("FAIL illegal zero: err/busy/ready/cpu_reset = %b, expected 1000 (cpu_reset kept low)",
                     {err, busy, byte_ready, cpu_reset});
        end
        repeat (3) tick();
        do_start(DEPTH + 1);
        checks++;
        if ({err, busy, byte_ready} !== 3'b100) begin
            errors++;
            $display("FAIL illegal over: err/busy/ready = %b, expected 100", {err, busy, byte_ready});
        end
        repeat (3) tick();
        checks++;
        if (wr_q.size() != wb || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL illegal idle: writes %0d ready %b, expected 0 0", wr_q.size() - wb, byte_ready);
        end
        load_and_verify("illegal_recover", 1, 0, bytes, cyc);
    endtask

    task automatic test_reload_abort();
        logic [7:0] bytes[$];
        int wb, cyc;
        bit ok;
        for (int i = 0; i < 2 * BYTES; i++) bytes.push_back(8'($urandom));
        // Reload from DONE, with a start pulse injected during RECV that must be ignored.
        do_start(2);
        checks++;
        if ({cpu_reset, done, busy} !== 3'b101) begin
            errors++;
            $display("FAIL reload: cpu_reset/done/busy = %b, expected 101", {cpu_reset, done, busy});
        end
        wb = wr_q.size();
        byte_valid = 1'b1;
        byte_data  = bytes[0];
        start      = 1'b1;
        word_count = 1;
        tick();
        start = 1'b0;
        feed(bytes[1:$], 0, cyc, ok);
        checks++;
        if (!ok || wr_q.size() - wb != 2) begin
            errors++;
            $display("FAIL ignored start: done %b writes %0d, expected 1 2", ok, wr_q.size() - wb);
        end
        checks++;
        if (wr_q.size() - wb == 2 &&
            (wr_q[wb].data !== {bytes[0], bytes[1]} || wr_q[wb + 1].data !== {bytes[2], bytes[3]})) begin
            errors++;
            $display("FAIL ignored start data: got %h %h, expected %h %h", wr_q[wb].data, wr_q[wb + 1].data,
                     {bytes[0], bytes[1]}, {bytes[2], bytes[3]});
        end
        // Abort after one of two bytes of the first word.
        do_start(2);
        wb = wr_q.size();
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        tick();
        byte_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, byte_ready, cpu_reset, imem_we, done} !== 5'b00100 || imem_addr !== '0) begin
            errors++;
            $display("FAIL abort: busy/ready/cpu_reset/we/done = %b addr %0d, expected 00100 0",
                     {busy, byte_ready, cpu_reset, imem_we, done}, imem_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (wr_q.size() != wb || {byte_ready, cpu_reset} !== 2'b01) begin
            errors++;
            $display("FAIL abort after: writes %0d ready/cpu_reset %b, expected 0 01",
                     wr_q.size() - wb, {byte_ready, cpu_reset});
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] bytes[$];
            int n = $urandom_range(1, DEPTH);
            int mode = $urandom_range(0, 2);
            int cyc;
            for (int i = 0; i < n * BYTES; i++) bytes.push_back(8'($urandom));
            load_and_verify($sformatf("random%0d", it), n, mode, bytes, cyc);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_full_depth();
        test_back_pressure();
        test_illegal_count();
        test_reload_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
